seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_pkg.sv | 29 ++
 rtl/seq_mul_if.sv | 23 ++
 rtl/seq_mul_ctrl.sv | 68 ++++++
 rtl/seq_mul.sv | 89 ++++++++
 tb/tb_seq_mul.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Ceiling log2; the down-counter must hold the value WIDTH itself.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int cnt_width(input int width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Request/response bundle of the multiplier, used by the bench to drive and observe it.
interface seq_mul_if import seq_mul_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// Sequencer of the multiplier: IDLE -> RUN (WIDTH steps) -> FIX, with the
// load/step/fix strobes that drive the datapath in seq_mul.
module seq_mul_ctrl import seq_mul_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic fix
);
    localparam int CW = cnt_width(WIDTH);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= (state_reg == FIX);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    cnt_next   = CW'(WIDTH);
                    state_next = RUN;
                end
            end
            RUN: begin
                step     = 1'b1;
                cnt_next = cnt_reg - CW'(1);
                // Leaving on the edge that brings the count to zero gives WIDTH steps.
                if (cnt_reg == CW'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                fix        = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: sign-magnitude operands, WIDTH add steps,
// then a final sign fix-up into the hi/lo result registers.
module seq_mul import seq_mul_pkg::*; #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int PW = 2 * WIDTH;

    logic             load, step, fix;
    logic             signed_mode;
    logic [WIDTH-1:0] opnd_raw [2];
    logic [WIDTH-1:0] opnd_mag [2];
    logic             opnd_msb [2];

    logic [PW-1:0]    mcand_reg;
    logic [PW-1:0]    acc_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [PW-1:0]    result;

    assign signed_mode = (SIGNED_EN != 0) && is_signed;
    assign opnd_raw[0] = multiplicand;
    assign opnd_raw[1] = multiplier;

    // The most-negative value negates to itself, which read unsigned is its true magnitude.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_opnd
        assign opnd_msb[gi] = opnd_raw[gi][WIDTH-1];
        assign opnd_mag[gi] = (signed_mode && opnd_msb[gi]) ? (WIDTH'(0) - opnd_raw[gi])
                                                            : opnd_raw[gi];
    end

    seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .load  (load),
        .step  (step),
        .fix   (fix)
    );

    assign result = neg_reg ? (PW'(0) - acc_reg) : acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            if (load) begin
                mcand_reg  <= {{WIDTH{1'b0}}, opnd_mag[0]};
                mplier_reg <= opnd_mag[1];
                acc_reg    <= '0;
                neg_reg    <= signed_mode && (opnd_msb[0] ^ opnd_msb[1]);
            end
            if (step) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mplier_reg <= mplier_reg >> 1;
                mcand_reg  <= mcand_reg << 1;
            end
            if (fix) begin
                {hi_reg, lo_reg} <= result;
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: driver queues expected products from an
// arithmetic reference; a monitor checks busy, hold, results and latency.
module tb_seq_mul;
    import seq_mul_pkg::*;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    seq_mul_if #(.WIDTH(W)) bus   ();
    seq_mul_if #(.WIDTH(W)) bus_u ();

    seq_mul #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (bus.start),
        .is_signed    (bus.is_signed),
        .multiplicand (bus.multiplicand),
        .multiplier   (bus.multiplier),
        .busy         (bus.busy),
        .done         (bus.done),
        .hi           (bus.hi),
        .lo           (bus.lo)
    );

    seq_mul #(.WIDTH(W), .SIGNED_EN(0)) dut_u (
        .clk          (clk),
        .reset        (reset),
        .start        (bus_u.start),
        .is_signed    (bus_u.is_signed),
        .multiplicand (bus_u.multiplicand),
        .multiplier   (bus_u.multiplier),
        .busy         (bus_u.busy),
        .done         (bus_u.done),
        .hi           (bus_u.hi),
        .lo           (bus_u.lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    exp_t           sb[$];
    exp_t           popped;
    logic [2*W-1:0] last_prod    = '0;
    bit             model_active = 1'b0;
    int             model_n      = 0;
    bit             exp_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        longint sa, sbv;
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            return 64'(sa * sbv);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            default: return $urandom;
        endcase
    endfunction

    // A request is taken if the model is idle at the coming edge; no queuing behind a busy unit.
    task automatic tick(input bit st, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start        = st;
        bus.is_signed    = s;
        bus.multiplicand = a;
        bus.multiplier   = b;
        if (st && (!model_active || (cyc + 1 >= model_n + W + 2))) begin
            model_active = 1'b1;
            model_n      = cyc + 1;
            sb.push_back('{prod: ref_mul(a, b, s), due: model_n + W + 1});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick(1'b0, 1'b0, '0, '0);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        tick(1'b0, 1'b0, '0, '0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            exp_busy = model_active && (cyc >= model_n) && (cyc <= model_n + W);
            check("busy", 64'(bus.busy), 64'(exp_busy));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    popped = sb.pop_front();
                    check("result", {bus.hi, bus.lo}, popped.prod);
                    check("latency", 64'(cyc), 64'(popped.due));
                    last_prod = popped.prod;
                    $display("txn done cycle %0d hi=%h lo=%h", cyc, bus.hi, bus.lo);
                end
            end else begin
                check("hold", {bus.hi, bus.lo}, last_prod);
                if (sb.size() != 0 && cyc > sb[0].due) begin
                    fail_now("missing_done");
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.start = 1'b0;  bus.is_signed = 1'b0;  bus.multiplicand = '0;  bus.multiplier = '0;
        bus_u.start = 1'b0; bus_u.is_signed = 1'b0; bus_u.multiplicand = '0; bus_u.multiplier = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Unsigned-only instance ignores is_signed.
        @(negedge clk);
        bus_u.start = 1'b1; bus_u.is_signed = 1'b1; bus_u.multiplicand = 32'd2; bus_u.multiplier = 32'd3;
        @(negedge clk);
        bus_u.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus_u.done;
        end
        check("unsigned_only_done", 64'(seen), 64'd1);
        check("unsigned_only_prod", {bus_u.hi, bus_u.lo}, 64'd6);
        $display("txn unsigned-only 2x3 hi=%h lo=%h", bus_u.hi, bus_u.lo);

        tick(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("ones_sq", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

        tick(1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7);
        drain();
        check("neg3x7_s", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        tick(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7);
        drain();
        check("neg3x7_u", {bus.hi, bus.lo}, 64'h0000_0006_FFFF_FFEB);

        tick(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
        drain();
        check("minneg_sq", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        // Second start while busy must be dropped.
        tick(1'b1, 1'b0, 32'd5, 32'd6);
        repeat (9) tick(1'b0, 1'b0, '0, '0);
        tick(1'b1, 1'b0, 32'd9, 32'd9);
        drain();
        check("busy_drop", {bus.hi, bus.lo}, 64'd30);
        repeat (40) tick(1'b0, 1'b0, '0, '0);

        // Reset in the middle of a run.
        tick(1'b1, 1'b1, 32'd4, 32'hFFFF_FFFB);
        repeat (14) tick(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        model_active = 1'b0;
        last_prod    = '0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 1'b0, 32'd4, 32'd4);
        drain();
        check("after_reset", {bus.hi, bus.lo}, 64'd16);

        // start held high across done gives back-to-back operations.
        for (int i = 0; i < 3 * (W + 2) + 2; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), pick(), pick());
        end
        drain();

        for (int k = 0; k < 25; k++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), pick(), pick());
            repeat ($urandom_range(0, 40)) begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick());
            end
        end
        drain();
        repeat (5) tick(1'b0, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
